// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops, shift-add multiply, optional restoring divide.
// Define ALU_DIV_EN to build the DIV state and divider datapath.
module alu_multicycle #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_JUMP = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_MOVE = 4'b0101;
  localparam logic [3:0] OP_SWAP = 4'b0110;
  localparam logic [3:0] OP_LOGIC = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1001;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'b0100;
`endif

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] work_hi, work_lo, opnd;
  logic [WIDTH-1:0] work_hi_n, work_lo_n, opnd_n;
  logic             load_res;
  logic [WIDTH-1:0] res_n, res_hi_n;
  logic             err_n;

  logic [WIDTH:0]   add_sum, sub_diff;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_err;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};

  // Results of the latency-1 operations
  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_err = 1'b0;
    case (operation)
      OP_JUMP:  ;
      OP_ADD:   begin sc_res = add_sum[WIDTH-1:0];  sc_hi = WIDTH'(add_sum[WIDTH]);  end
      OP_SUB:   begin sc_res = sub_diff[WIDTH-1:0]; sc_hi = WIDTH'(sub_diff[WIDTH]); end
      OP_MOVE:  sc_res = b;
      OP_SWAP:  begin sc_res = b; sc_hi = a; end
      OP_LOGIC: begin sc_res = a & b; sc_hi = a | b; end
      OP_CMP:   begin sc_res = WIDTH'(a == b); sc_hi = WIDTH'(sub_diff[WIDTH]); end
      default:  sc_err = 1'b1;
    endcase
  end

  // One shift-add step: {hi,lo} holds partial product with multiplier in lo
  always_comb begin
    mul_sum = {1'b0, work_hi} + {1'b0, opnd};
    if (work_lo[0]) {mul_hi_n, mul_lo_n} = {mul_sum, work_lo[WIDTH-1:1]};
    else            {mul_hi_n, mul_lo_n} = {1'b0, work_hi, work_lo[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_shift, div_trial;
  logic [WIDTH-1:0] div_rem_n, div_quo_n;

  // One restoring step: hi is the partial remainder, lo shifts dividend out / quotient in
  always_comb begin
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    if (!div_trial[WIDTH]) begin
      div_rem_n = div_trial[WIDTH-1:0];
      div_quo_n = {work_lo[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_n = div_shift[WIDTH-1:0];
      div_quo_n = {work_lo[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_next = state;
    load_res   = 1'b0;
    res_n      = '0;
    res_hi_n   = '0;
    err_n      = 1'b0;
    work_hi_n  = work_hi;
    work_lo_n  = work_lo;
    opnd_n     = opnd;
    case (state)
      IDLE: begin
        if (start) begin
          case (operation)
            OP_MUL: begin
              state_next = MUL;
              work_hi_n  = '0;
              work_lo_n  = b;
              opnd_n     = a;
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
              if (b == '0) begin
                state_next = DONE;
                load_res   = 1'b1;
                res_n      = '1;
                res_hi_n   = a;
                err_n      = 1'b1;
              end else begin
                state_next = DIV;
                work_hi_n  = '0;
                work_lo_n  = a;
                opnd_n     = b;
              end
            end
`endif
            default: begin
              state_next = DONE;
              load_res   = 1'b1;
              res_n      = sc_res;
              res_hi_n   = sc_hi;
              err_n      = sc_err;
            end
          endcase
        end
      end
      MUL: begin
        work_hi_n = mul_hi_n;
        work_lo_n = mul_lo_n;
        if (cnt == LAST) begin
          state_next = DONE;
          load_res   = 1'b1;
          res_n      = mul_lo_n;
          res_hi_n   = mul_hi_n;
        end
      end
`ifdef ALU_DIV_EN
      DIV: begin
        work_hi_n = div_rem_n;
        work_lo_n = div_quo_n;
        if (cnt == LAST) begin
          state_next = DONE;
          load_res   = 1'b1;
          res_n      = div_quo_n;
          res_hi_n   = div_rem_n;
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      opnd      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      err       <= 1'b0;
    end else begin
      state   <= state_next;
      work_hi <= work_hi_n;
      work_lo <= work_lo_n;
      opnd    <= opnd_n;
      if (state == IDLE || state == DONE) cnt <= '0;
      else                                cnt <= cnt + CW'(1);
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (load_res) begin
        result    <= res_n;
        result_hi <= res_hi_n;
        zero      <= (res_n == '0);
        err       <= err_n;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle against an arithmetic reference model.
// Expectations for opcode 0100 follow the ALU_DIV_EN macro.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  operation;
  logic [15:0] a, b;
  logic        busy, done, zero, err;
  logic [15:0] result, result_hi;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operands, plus the expected latency
  task automatic model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic [15:0] h, output logic e,
                       output int lat);
    logic [31:0] p;
    r = 16'h0; h = 16'h0; e = 1'b0; lat = 1;
    case (op)
      4'h0: ;
      4'h1: begin p = 32'(x) + 32'(y); r = p[15:0]; h = p[31:16]; end
      4'h2: begin r = x - y; h = (x < y) ? 16'h1 : 16'h0; end
      4'h3: begin p = 32'(x) * 32'(y); r = p[15:0]; h = p[31:16]; lat = 17; end
`ifdef ALU_DIV_EN
      4'h4: begin
        if (y == 16'h0) begin r = 16'hFFFF; h = x; e = 1'b1; end
        else begin r = x / y; h = x % y; lat = 17; end
      end
`endif
      4'h5: r = y;
      4'h6: begin r = y; h = x; end
      4'h7: begin r = x & y; h = x | y; end
      4'h9: begin r = (x == y) ? 16'h1 : 16'h0; h = (x < y) ? 16'h1 : 16'h0; end
      default: e = 1'b1;
    endcase
  endtask

  // Issue one op from idle, scramble operands while busy, observe until done
  task automatic run_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output logic [15:0] r, output logic [15:0] h,
                        output logic z, output logic e, output int bc,
                        output bit pulse_ok, output bit stable);
    logic [15:0] prev_r, prev_h;
    prev_r = result; prev_h = result_hi;
    start = 1'b1; operation = op; a = x; b = y;
    step();
    start = 1'b0;
    lat = 1; bc = 0; stable = 1'b1;
    while (!done && lat < 64) begin
      if (busy) bc++;
      if (result !== prev_r || result_hi !== prev_h) stable = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      step();
      lat++;
    end
    if (busy) bc++;
    r = result; h = result_hi; z = zero; e = err;
    step();
    pulse_ok = !done && !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; operation = 4'h0; a = 16'h0; b = 16'h0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({result, result_hi, zero, busy, done, err} !== {16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got r=%h h=%h z=%b busy=%b done=%b err=%b, want r=0 h=0 z=1 busy=0 done=0 err=0",
               result, result_hi, zero, busy, done, err);
    end
  endtask

  task automatic test_add();
    logic [15:0] xs [3] = '{16'hFFFF, 16'h1234, 16'h8000};
    logic [15:0] ys [3] = '{16'h0001, 16'h4321, 16'h8000};
    int lat, bc, el; logic [15:0] r, h, er, eh; logic z, e, ee; bit pok, stb;
    for (int i = 0; i < 3; i++) begin
      model(4'h1, xs[i], ys[i], er, eh, ee, el);
      run_op(4'h1, xs[i], ys[i], lat, r, h, z, e, bc, pok, stb);
      checks++;
      if ({lat, r, h, z, e, bc, pok, stb} !== {el, er, eh, er == 16'h0, ee, el, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL add a=%h b=%h: got lat=%0d r=%h h=%h z=%b e=%b busy=%0d pulse=%b stable=%b, want lat=%0d r=%h h=%h e=%b",
                 xs[i], ys[i], lat, r, h, z, e, bc, pok, stb, el, er, eh, ee);
      end
    end
  endtask

  task automatic test_mult();
    int lat, bc, el; logic [15:0] x, y, r, h, er, eh; logic z, e, ee; bit pok, stb;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin x = 16'h1234; y = 16'h5678; end
        1: begin x = 16'hFFFF; y = 16'hFFFF; end
        2: begin x = 16'h0000; y = 16'hBEEF; end
        default: begin x = 16'($urandom); y = 16'($urandom); end
      endcase
      model(4'h3, x, y, er, eh, ee, el);
      run_op(4'h3, x, y, lat, r, h, z, e, bc, pok, stb);
      checks++;
      if ({lat, r, h, z, e, bc, pok, stb} !== {el, er, eh, er == 16'h0, ee, el, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL mult a=%h b=%h: got lat=%0d r=%h h=%h z=%b e=%b busy=%0d pulse=%b stable=%b, want lat=%0d r=%h h=%h e=%b",
                 x, y, lat, r, h, z, e, bc, pok, stb, el, er, eh, ee);
      end
    end
  endtask

  task automatic test_div();
    int lat, bc, el; logic [15:0] x, y, r, h, er, eh; logic z, e, ee; bit pok, stb;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin x = 16'h0064; y = 16'h0007; end
        1: begin x = 16'h0064; y = 16'h0000; end
        2: begin x = 16'hFFFF; y = 16'h0001; end
        3: begin x = 16'h0003; y = 16'hFFFF; end
        default: begin
          x = 16'($urandom);
          y = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 300));
        end
      endcase
      model(4'h4, x, y, er, eh, ee, el);
      run_op(4'h4, x, y, lat, r, h, z, e, bc, pok, stb);
      checks++;
      if ({lat, r, h, z, e, bc, pok, stb} !== {el, er, eh, er == 16'h0, ee, el, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL div a=%h b=%h: got lat=%0d r=%h h=%h z=%b e=%b busy=%0d pulse=%b stable=%b, want lat=%0d r=%h h=%h e=%b",
                 x, y, lat, r, h, z, e, bc, pok, stb, el, er, eh, ee);
      end
    end
  endtask

  task automatic test_random_ops();
    int lat, bc, el; logic [3:0] op; logic [15:0] x, y, r, h, er, eh; logic z, e, ee; bit pok, stb;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      x = 16'($urandom); y = 16'($urandom);
      if (i % 5 == 0) y = x;
      model(op, x, y, er, eh, ee, el);
      run_op(op, x, y, lat, r, h, z, e, bc, pok, stb);
      checks++;
      if ({lat, r, h, z, e, bc, pok, stb} !== {el, er, eh, er == 16'h0, ee, el, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL op%h a=%h b=%h: got lat=%0d r=%h h=%h z=%b e=%b busy=%0d pulse=%b stable=%b, want lat=%0d r=%h h=%h e=%b",
                 op, x, y, lat, r, h, z, e, bc, pok, stb, el, er, eh, ee);
      end
    end
  endtask

  // Mult aborted by reset; an add pulsed mid-operation must be ignored
  task automatic test_reset_abort();
    logic [15:0] held;
    bit quiet;
    start = 1'b1; operation = 4'h6; a = 16'h0F0F; b = 16'hC3C3;
    step(); start = 1'b0; step();
    held = result;
    start = 1'b1; operation = 4'h3; a = 16'h1234; b = 16'h5678;
    step();
    start = 1'b0;
    quiet = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (done || !busy || result !== held) quiet = 1'b0;
      if (c == 5) begin start = 1'b1; operation = 4'h1; a = 16'h0001; b = 16'h0001; end
      if (c == 6) start = 1'b0;
      if (c == 10) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    checks++;
    if (!quiet || held !== 16'hC3C3) begin
      errors++;
      $display("FAIL abort_busy: got quiet=%b held=%h, want quiet=1 held=c3c3", quiet, held);
    end
    checks++;
    if ({result, result_hi, zero, busy, done, err} !== {16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset: got r=%h h=%h z=%b busy=%b done=%b err=%b, want reset values",
               result, result_hi, zero, busy, done, err);
    end
    start = 1'b1; operation = 4'h1; a = 16'h0002; b = 16'h0003;
    step();
    start = 1'b0;
    checks++;
    if ({done, result, result_hi} !== {1'b1, 16'h0005, 16'h0000}) begin
      errors++;
      $display("FAIL abort_restart: got done=%b r=%h h=%h, want done=1 r=0005 h=0000", done, result, result_hi);
    end
    step();
  endtask

  // Swap with start held through DONE, then an illegal op on the first idle cycle
  task automatic test_back_to_back();
    start = 1'b1; operation = 4'h6; a = 16'hAAAA; b = 16'h5555;
    step();
    checks++;
    if ({done, busy, result, result_hi, err} !== {1'b1, 1'b1, 16'h5555, 16'hAAAA, 1'b0}) begin
      errors++;
      $display("FAIL b2b_swap: got done=%b busy=%b r=%h h=%h e=%b, want 1 1 5555 aaaa 0",
               done, busy, result, result_hi, err);
    end
    step();
    checks++;
    if ({done, busy, result} !== {1'b0, 1'b0, 16'h5555}) begin
      errors++;
      $display("FAIL b2b_ignore: got done=%b busy=%b r=%h, want 0 0 5555", done, busy, result);
    end
    operation = 4'hF;
    step();
    start = 1'b0;
    checks++;
    if ({done, result, result_hi, zero, err} !== {1'b1, 16'h0, 16'h0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_illegal: got done=%b r=%h h=%h z=%b e=%b, want 1 0000 0000 1 1",
               done, result, result_hi, zero, err);
    end
    step();
    checks++;
    if ({done, busy, err} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_hold: got done=%b busy=%b e=%b, want 0 0 1", done, busy, err);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult();
    test_div();
    test_random_ops();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; iteration count of multiply and divide.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request; accepted only while busy=0.
REQ-005 operation  input  4  operation code from ALU control stage.
REQ-006 a, b  input  WIDTH each  operands; sampled on the accepting edge only.
REQ-007 busy  output  1  high from the edge after acceptance through the done cycle inclusive.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 result, result_hi  output  WIDTH each  primary/secondary results, registered.
REQ-010 zero  output  1  result==0, registered with result.
REQ-011 err  output  1  illegal op or divide-by-zero, registered with result.

Function
REQ-012 FSM states IDLE, MUL, DIV, DONE; start&&!busy in IDLE goes to MUL (0011), DIV (0100) or DONE (all other codes).
REQ-013 Single-cycle ops write result/result_hi/zero/err on the accepting edge; done=1 the next cycle (latency 1).
REQ-014 0000 jump/halt: result=0, result_hi=0.
REQ-015 0001 add: result=(a+b) mod 2^WIDTH, result_hi=carry-out in bit 0.
REQ-016 0010 sub: result=(a-b) mod 2^WIDTH, result_hi bit 0=borrow.
REQ-017 0011 mult: unsigned shift-add, one bit per cycle, WIDTH cycles in MUL; result=product low, result_hi=product high; done WIDTH+1 cycles after acceptance.
REQ-018 0100 div: unsigned restoring, WIDTH cycles in DIV; result=quotient, result_hi=remainder; done WIDTH+1 cycles after acceptance.
REQ-019 Divide by zero: no DIV iterations, go to DONE directly; result=all ones, result_hi=a, err=1, latency 1.
REQ-020 0101 move: result=b, result_hi=0.
REQ-021 0110 swap: result=b, result_hi=a.
REQ-022 0111 logic: result=a&b, result_hi=a|b.
REQ-023 1001 compare: result bit0=(a==b), result_hi bit0=(a<b unsigned), other bits 0.
REQ-024 Any other code: result=0, result_hi=0, err=1, latency 1.
REQ-025 DONE always returns to IDLE next edge; busy=0 in IDLE.
REQ-026 start while busy=1 (including DONE cycle) ignored, no queueing; earliest re-acceptance is the cycle after done.
REQ-027 Outputs hold their last value from done until the next accepting edge; operand changes while busy have no effect.
REQ-028 zero and err refer to the final result only; intermediate iteration values never appear on result/result_hi.

Reset
REQ-029 rst=1 at an edge: state=IDLE, busy=0, done=0, result=0, result_hi=0, zero=1, err=0, iteration counter and working registers cleared.
REQ-030 rst overrides start and aborts any MUL/DIV in progress; no done pulse for the aborted operation.

Configuration
REQ-031 Macro ALU_DIV_EN: defined, divide behaves per REQ-018/019; undefined, DIV state and divider datapath are not built and 0100 is treated per REQ-024 (err=1, latency 1).

Verification
REQ-032 Reset then idle: rst high 2 cycles -> result=0, zero=1, busy=0, done=0, err=0.
REQ-033 add a=0xFFFF b=0x0001 -> done 1 cycle later, result=0x0000, result_hi=0x0001, zero=1.
REQ-034 mult a=0x1234 b=0x5678 -> done exactly 17 cycles after acceptance, result=0x0060, result_hi=0x0626, busy high 17 cycles.
REQ-035 div a=0x0064 b=0x0007 (ALU_DIV_EN defined) -> done at cycle 17, result=0x000E, result_hi=0x0002; b=0 -> latency 1, result=0xFFFF, result_hi=0x0064, err=1; ALU_DIV_EN undefined -> result=0, err=1.
REQ-036 mult in progress, start with add pulsed at cycle 5, then rst at cycle 10 -> add ignored, no done, all outputs at reset values cycle 11, new start accepted cycle 11.
REQ-037 swap a=0xAAAA b=0x5555, then opcode 1111 -> result=0x5555/result_hi=0xAAAA, then result=0, err=1, done pulses of one cycle each.
